// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: requester-side and transmitter-side signals of tx_arbiter.
// The arbiter uses the master modport; the requesters/transmitter side uses slave.
interface tx_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ack;
  logic               tx_start;
  logic [WIDTH-1:0]   tx_pi;
  logic               tx_busy;
  logic [IDW-1:0]     grant_id;
  logic               active;
  logic               wdt_err;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ack, tx_start, tx_pi, grant_id, active, wdt_err
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ack, tx_start, tx_pi, grant_id, active, wdt_err
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter sharing one start/busy serial transmitter among N requesters.
// Define TX_ARBITER_WDT_EN to enable the transmitter handshake watchdog (wdt_err).
module tx_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 0,
  parameter int unsigned WDT_LIMIT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_arbiter_if.master bus
);
  localparam int unsigned IDW      = $clog2(N);
  localparam logic [7:0]  GAP_LOAD = 8'((GAP > 0) ? GAP - 1 : 0);

  if (N < 2 || N > 16 || GAP > 255 || WDT_LIMIT < 1 || WDT_LIMIT > 255) begin : g_bad_cfg
    $error("tx_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [N-1:0]     req_ack_q, req_ack_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             win_found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;

`ifdef TX_ARBITER_WDT_EN
  localparam logic [7:0] WDT_LIM = 8'(WDT_LIMIT);
  logic [7:0] wdt_cnt_q, wdt_cnt_d;
  logic       wdt_err_q, wdt_err_d;
`endif

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    win_found = 1'b0;
    winner    = rr_ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % N);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
    req_ack_d  = '0;
    gap_cnt_d  = gap_cnt_q;
`ifdef TX_ARBITER_WDT_EN
    wdt_cnt_d  = wdt_cnt_q;
    wdt_err_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found && !bus.tx_busy) begin
          state_d           = S_START;
          rr_ptr_d          = winner;
          grant_id_d        = winner;
          hold_d            = bus.req_data[winner*WIDTH +: WIDTH];
          req_ack_d[winner] = 1'b1;
        end
      end
      S_START: begin
        state_d   = S_WAIT_BUSY;
`ifdef TX_ARBITER_WDT_EN
        wdt_cnt_d = '0;
`endif
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d   = S_WAIT_DONE;
`ifdef TX_ARBITER_WDT_EN
          // The busy cycle that ends WAIT_BUSY counts toward the frame limit.
          wdt_cnt_d = 8'd1;
        end else if (wdt_cnt_q == 8'd3) begin
          state_d   = S_IDLE;
          wdt_err_d = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 8'd1;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d   = (GAP > 0) ? S_GAP : S_IDLE;
          gap_cnt_d = GAP_LOAD;
`ifdef TX_ARBITER_WDT_EN
        end else if (wdt_cnt_q >= WDT_LIM) begin
          state_d   = S_IDLE;
          wdt_err_d = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 8'd1;
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= IDW'(N - 1);
      grant_id_q <= '0;
      hold_q     <= '0;
      req_ack_q  <= '0;
      gap_cnt_q  <= '0;
`ifdef TX_ARBITER_WDT_EN
      wdt_cnt_q  <= '0;
      wdt_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
      req_ack_q  <= req_ack_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef TX_ARBITER_WDT_EN
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_err_q  <= wdt_err_d;
`endif
    end
  end

  assign bus.req_ack  = req_ack_q;
  assign bus.tx_start = (state_q == S_START);
  assign bus.tx_pi    = hold_q;
  assign bus.grant_id = grant_id_q;
  assign bus.active   = (state_q != S_IDLE);
`ifdef TX_ARBITER_WDT_EN
  assign bus.wdt_err  = wdt_err_q;
`else
  assign bus.wdt_err  = 1'b0;
`endif
endmodule
